// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: small instruction buffer in front of a req/ack instruction bus.
// Define IFETCH_CACHE_EN for a direct-mapped 2^IDX_W entry buffer; otherwise one last-word entry.
module inst_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_ce_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic              state_o
);

`ifdef IFETCH_CACHE_EN
  localparam int NENT  = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int IX_W  = IDX_W;
`else
  localparam int NENT  = 1;
  localparam int TAG_W = ADDR_W - 2;
  localparam int IX_W  = 1;
  localparam int unused_idx_w = IDX_W;
`endif

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t              state_q;
  logic                bus_req_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic                discard_q;
  logic [NENT-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [NENT];
  logic [DATA_W-1:0]   data_q [NENT];

  logic [IX_W-1:0]     cpu_idx;
  logic [IX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]    cpu_tag;
  logic [TAG_W-1:0]    fill_tag;
  logic                hit;
  logic                fill_we;
  logic                unused_low_bits;

  always_comb begin
`ifdef IFETCH_CACHE_EN
    cpu_idx  = cpu_addr_i[IDX_W+1:2];
    cpu_tag  = cpu_addr_i[ADDR_W-1:IDX_W+2];
    fill_idx = bus_addr_q[IDX_W+1:2];
    fill_tag = bus_addr_q[ADDR_W-1:IDX_W+2];
`else
    cpu_idx  = '0;
    cpu_tag  = cpu_addr_i[ADDR_W-1:2];
    fill_idx = '0;
    fill_tag = bus_addr_q[ADDR_W-1:2];
`endif
  end

  assign unused_low_bits = ^{cpu_addr_i[1:0], bus_addr_q[1:0]};

  // A flush in the same cycle forces a miss so the core never sees a word being invalidated.
  assign hit        = cpu_ce_i & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag) & ~flush_i;
  assign cpu_data_o = hit ? data_q[cpu_idx] : '0;
  assign stallreq_o = cpu_ce_i & ~hit;

  assign fill_we    = (state_q == REQ) & bus_ack_i & ~flush_i & ~discard_q;

  assign bus_req_o  = bus_req_q;
  assign bus_addr_o = bus_addr_q;
  assign state_o    = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      discard_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      if (flush_i) valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (cpu_ce_i && !hit) begin
            bus_addr_q <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
            bus_req_q  <= 1'b1;
            discard_q  <= 1'b0;
            state_q    <= REQ;
          end
        end
        REQ: begin
          // A flush during the transfer poisons the word that is still in flight.
          if (flush_i) discard_q <= 1'b1;
          if (bus_ack_i) begin
            bus_req_q <= 1'b0;
            discard_q <= 1'b0;
            state_q   <= IDLE;
            if (fill_we) valid_q[fill_idx] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus_data_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: random fetch streams against a word-level buffer model, plus directed corner cases.
module tb_inst_fetch_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef IFETCH_CACHE_EN
  localparam int NL = 1 << IW;
`else
  localparam int NL = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic          cpu_ce_i = 1'b0;
  logic [DW-1:0] cpu_data_o;
  logic          stallreq_o;
  logic          flush_i;
  logic          bus_req_o;
  logic [AW-1:0] bus_addr_o;
  logic          bus_ack_i;
  logic [DW-1:0] bus_data_i;
  logic          state_o;

  inst_fetch_bridge #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr_i), .cpu_ce_i(cpu_ce_i),
    .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
    .bus_ack_i(bus_ack_i), .bus_data_i(bus_data_i),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_stall_q[$];

  int            cur_wait = 0;
  bit            flush_on_ack = 1'b0;
  bit            spurious_ack = 1'b0;
  logic [AW-1:0] exp_fill_addr = '0;
  int            ack_cnt = 0;
  int            miss_cnt = 0;

  bit            line_v[NL];
  logic [29:0]   line_word[NL];

  function automatic int line_of(input logic [31:0] a);
`ifdef IFETCH_CACHE_EN
    return int'(a[IW+1:2]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:2] == 30'd1) return 32'h34010100;
    w = {a[31:2], 2'b00} * 32'h9E3779B1;
    return w ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic abort_run(input string name);
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench aborted");
  endtask

  // Monitor: one scoreboard entry per fetch, consumed on the cycle the core gets its word.
  int stall_cnt = 0;
  initial begin
    logic [DW-1:0] ed;
    int es;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0;
      end else if (cpu_ce_i) begin
        if (stallreq_o) begin
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          ed = exp_q.pop_front();
          es = exp_stall_q.pop_front();
          check("fetch_data", cpu_data_o, ed);
          check("stall_cycles", stall_cnt, es);
          stall_cnt = 0;
        end
      end else begin
        check("ce0_data", cpu_data_o, 0);
        check("ce0_stall", stallreq_o, 0);
        stall_cnt = 0;
      end
    end
  end

  // Bus responder: acks after cur_wait wait cycles; can pair an ack with a flush.
  initial begin
    int wcnt;
    wcnt = 0;
    bus_ack_i = 1'b0;
    bus_data_i = '0;
    flush_i = 1'b0;
    forever begin
      @(negedge clk);
      bus_ack_i = 1'b0;
      flush_i = 1'b0;
      if (!rst) begin
        wcnt = 0;
      end else if (bus_req_o) begin
        if (wcnt >= cur_wait) begin
          bus_ack_i = 1'b1;
          bus_data_i = mem_word(bus_addr_o);
          ack_cnt++;
          check("bus_addr", bus_addr_o, exp_fill_addr);
          wcnt = 0;
          if (flush_on_ack) begin
            flush_i = 1'b1;
            flush_on_ack = 1'b0;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (spurious_ack) begin
          bus_ack_i = 1'b1;
          bus_data_i = 32'hDEAD_BEEF;
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stallreq_o) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    abort_run("fetch_wait");
  endtask

  task automatic do_fetch(input logic [31:0] a, input int w, input bit fa);
    int ln;
    bit h;
    int stalls;
    ln = line_of(a);
    h = line_v[ln] && (line_word[ln] == a[31:2]);
    stalls = 0;
    if (!h) begin
      stalls = 2 + w;
      miss_cnt++;
      if (fa) begin
        stalls += 2 + w;
        miss_cnt++;
        foreach (line_v[i]) line_v[i] = 1'b0;
      end
      line_v[ln] = 1'b1;
      line_word[ln] = a[31:2];
    end
    exp_q.push_back(mem_word(a));
    exp_stall_q.push_back(stalls);
    cur_wait = w;
    flush_on_ack = fa && !h;
    exp_fill_addr = {a[31:2], 2'b00};
    spurious_ack = 1'b0;
    cpu_addr_i = a;
    cpu_ce_i = 1'b1;
    wait_done();
  endtask

  task automatic idle_cycles(input int n, input bit spur);
    cpu_ce_i = 1'b0;
    spurious_ack = spur;
    for (int i = 0; i < n; i++) begin
      cpu_addr_i = $urandom;
      @(negedge clk);
      check("ce0_no_req", bus_req_o, 0);
      @(posedge clk);
      #1;
    end
    spurious_ack = 1'b0;
  endtask

  task automatic reset_mid_req();
    bit seen;
    seen = 1'b0;
    cpu_addr_i = 32'h0000_0020;
    cpu_ce_i = 1'b1;
    cur_wait = 50;
    exp_fill_addr = 32'h0000_0020;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus_req_o;
    end
    if (!seen) abort_run("req_before_rst");
    #2 rst = 1'b0;
    #1;
    check("rst_req_drop", bus_req_o, 0);
    check("rst_state_idle", state_o, 0);
    check("rst_bus_addr", bus_addr_o, 0);
    cpu_ce_i = 1'b0;
    #1;
    check("rst_ce0_stall", stallreq_o, 0);
    check("rst_ce0_data", cpu_data_o, 0);
    foreach (line_v[i]) line_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    foreach (line_v[i]) line_v[i] = 1'b0;
    foreach (line_word[i]) line_word[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_req", bus_req_o, 0);
    check("reset_addr", bus_addr_o, 0);
    check("reset_state", state_o, 0);
    check("reset_stall", stallreq_o, 0);
    check("reset_data", cpu_data_o, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    do_fetch(32'h0000_0004, 3, 1'b0);
    do_fetch(32'h0000_0004, 2, 1'b0);
    do_fetch(32'h0000_0008, 1, 1'b0);
    do_fetch(32'h0000_0006, 2, 1'b0);
    do_fetch(32'h0000_0000, 0, 1'b0);
    do_fetch(32'h0000_0010, 1, 1'b0);
    do_fetch(32'h0000_0000, 2, 1'b0);
    do_fetch(32'h0000_000C, 2, 1'b1);
    idle_cycles(5, 1'b1);
    do_fetch(32'h0000_000C, 1, 1'b0);
    do_fetch(32'h0000_0004, 1, 1'b0);
    reset_mid_req();
    do_fetch(32'h0000_0004, 1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 1) != 0 ? 32'h0000_1000 : 32'h0) + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      do_fetch(a, $urandom_range(0, 4), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3), $urandom_range(0, 1) != 0);
    end

    idle_cycles(4, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);
    check("bus_req_count", ack_cnt, miss_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
